tile_scheduler: RTL and testbench

//  Parametrised frame/tile sequencer between the tiled rasterizer and the framebuffer streamer.

---
 rtl/typhoon_pkg.sv | 22 ++
 rtl/tile_coord_walker.sv | 50 +++++
 rtl/tile_scheduler.sv | 149 ++++++++++++++
 tb/tb_tile_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/typhoon_pkg.sv
// Shared types and helpers for the tile scheduler slice.
// Scheduler states, tile buffer states and tile-count arithmetic.
package typhoon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLIP
  } sched_state_t;

  typedef enum logic [1:0] {
    FREE,
    RASTER,
    FULL,
    STREAM
  } buf_state_t;

  function automatic int tiles_along(input int len, input int dim);
    return (len + dim - 1) / dim;
  endfunction

endpackage

// File: rtl/tile_coord_walker.sv
// Row-major tile origin stepper with a consumed-tile counter.
// Holds the last origin once every tile has been stepped past.
module tile_coord_walker #(
  parameter int CW       = 10,
  parameter int TILE_DIM = 8,
  parameter int TILES_X  = 80,
  parameter int TILES_Y  = 60,
  parameter int NW       = $clog2(TILES_X * TILES_Y + 1)
) (
  input  logic          BOARD_CLK,
  input  logic          RESET_N,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [NW-1:0] cnt
);

  localparam logic [CW-1:0] LastX = CW'((TILES_X - 1) * TILE_DIM);
  localparam logic [CW-1:0] LastY = CW'((TILES_Y - 1) * TILE_DIM);
  localparam logic [CW-1:0] Pitch = CW'(TILE_DIM);
  localparam logic [NW-1:0] Total = NW'(TILES_X * TILES_Y);

  logic atEnd;

  assign atEnd = (x == LastX) && (y == LastY);

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x   <= '0;
      y   <= '0;
      cnt <= '0;
    end else if (clear) begin
      x   <= '0;
      y   <= '0;
      cnt <= '0;
    end else if (step && cnt != Total) begin
      cnt <= cnt + NW'(1);
      if (!atEnd) begin
        if (x == LastX) begin
          x <= '0;
          y <= y + Pitch;
        end else begin
          x <= x + Pitch;
        end
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Frame/tile sequencer feeding a rasterizer and an SRAM streamer
// through a FIFO ring of NUM_BUFS tile buffers.
module tile_scheduler
  import typhoon_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TILE_DIM = 8,
  parameter int NUM_BUFS = 2,
  parameter int CW       = 10,
  parameter int BW       = $clog2(NUM_BUFS)
) (
  input  logic          BOARD_CLK,
  input  logic          RESET_N,
  input  logic          frame_start,
  output logic          raster_start,
  output logic [CW-1:0] raster_x,
  output logic [CW-1:0] raster_y,
  output logic [BW-1:0] raster_buf,
  input  logic          raster_done,
  output logic          stream_start,
  output logic [CW-1:0] stream_x,
  output logic [CW-1:0] stream_y,
  output logic [BW-1:0] stream_buf,
  input  logic          stream_done,
  output logic          front_buffer,
  output logic          frame_done,
  output logic          busy
);

  localparam int TilesX = tiles_along(SCREEN_W, TILE_DIM);
  localparam int TilesY = tiles_along(SCREEN_H, TILE_DIM);
  localparam int Nt     = TilesX * TilesY;
  localparam int NW     = $clog2(Nt + 1);
  localparam int FW     = $clog2(NUM_BUFS + 1);
  localparam logic [BW-1:0] LastBuf = BW'(NUM_BUFS - 1);

  sched_state_t  state, stateNext;
  buf_state_t    bufState [NUM_BUFS];
  logic [BW-1:0] rPtr, sPtr;
  logic [FW-1:0] fc;
  logic [NW-1:0] rCnt, sCnt;
  logic          rasterBusy, streamBusy;
  logic          frameGo, rIssue, rDone, sIssue, sDone, sLast;

  function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
    return (p == LastBuf) ? '0 : p + BW'(1);
  endfunction

  assign frameGo = (state == IDLE) && frame_start;
  assign rDone   = rasterBusy && raster_done;
  assign sDone   = streamBusy && stream_done;
  assign rIssue  = (state == RUN) && !rasterBusy &&
                   (rCnt != NW'(Nt)) && (bufState[rPtr] == FREE);
  assign sIssue  = (state == RUN) && !streamBusy && (fc != '0);
  assign sLast   = sDone && (sCnt == NW'(Nt - 1));

  assign frame_done = (state == FLIP);
  assign busy       = (state != IDLE);

  tile_coord_walker #(
    .CW(CW), .TILE_DIM(TILE_DIM),
    .TILES_X(TilesX), .TILES_Y(TilesY), .NW(NW)
  ) rasterWalk (
    .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N),
    .clear(frameGo), .step(rDone),
    .x(raster_x), .y(raster_y), .cnt(rCnt)
  );

  tile_coord_walker #(
    .CW(CW), .TILE_DIM(TILE_DIM),
    .TILES_X(TilesX), .TILES_Y(TilesY), .NW(NW)
  ) streamWalk (
    .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N),
    .clear(frameGo), .step(sDone),
    .x(stream_x), .y(stream_y), .cnt(sCnt)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (frame_start) stateNext = RUN;
      RUN:     if (sLast) stateNext = FLIP;
      FLIP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      front_buffer <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == RUN && stateNext == FLIP)
        front_buffer <= ~front_buffer;
    end
  end

  // Issue and retire touch different buffers in any one cycle, so the
  // per-index writes below never collide.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_BUFS; i++) bufState[i] <= FREE;
      rPtr         <= '0;
      sPtr         <= '0;
      fc           <= '0;
      rasterBusy   <= 1'b0;
      streamBusy   <= 1'b0;
      raster_start <= 1'b0;
      stream_start <= 1'b0;
      raster_buf   <= '0;
      stream_buf   <= '0;
    end else begin
      raster_start <= rIssue;
      stream_start <= sIssue;
      if (frameGo) begin
        rPtr <= '0;
        sPtr <= '0;
        fc   <= '0;
      end
      if (rIssue) begin
        rasterBusy     <= 1'b1;
        bufState[rPtr] <= RASTER;
        raster_buf     <= rPtr;
      end
      if (rDone) begin
        rasterBusy     <= 1'b0;
        bufState[rPtr] <= FULL;
        rPtr           <= bump(rPtr);
      end
      if (sIssue) begin
        streamBusy     <= 1'b1;
        bufState[sPtr] <= STREAM;
        stream_buf     <= sPtr;
      end
      if (sDone) begin
        streamBusy     <= 1'b0;
        bufState[sPtr] <= FREE;
        sPtr           <= bump(sPtr);
      end
      if (rDone && !sDone)
        fc <= fc + FW'(1);
      else if (sDone && !rDone)
        fc <= fc - FW'(1);
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: 32x16 screen (8 tiles, 2 buffers)
// and 36x16 screen (10 tiles, 4 buffers).
module tb_tile_scheduler;

  logic       BOARD_CLK = 1'b0;
  logic       RESET_N;
  logic       frame_start, raster_done, stream_done;
  logic       raster_start, stream_start;
  logic [9:0] raster_x, raster_y, stream_x, stream_y;
  logic [0:0] raster_buf, stream_buf;
  logic       front_buffer, frame_done, busy;

  logic       frame_startW, raster_doneW, stream_doneW;
  logic       raster_startW, stream_startW;
  logic [9:0] raster_xW, raster_yW, stream_xW, stream_yW;
  logic [1:0] raster_bufW, stream_bufW;
  logic       front_bufferW, frame_doneW, busyW;

  int nChecks = 0;
  int nFails  = 0;

  int  rPend = -1, sPend = -1, rPendW = -1, sPendW = -1;
  bit  autoR = 1'b1, autoS = 1'b1, stallS = 1'b0;
  int  sDones = 0, fdCnt = 0, fdCntW = 0;
  logic [31:0] rLog[$], sLog[$], rLogW[$], sLogW[$];
  int  rSnap[$];

  always #5 BOARD_CLK = ~BOARD_CLK;

  tile_scheduler #(
    .SCREEN_W(32), .SCREEN_H(16), .TILE_DIM(8),
    .NUM_BUFS(2), .CW(10)
  ) dut (
    .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N),
    .frame_start(frame_start),
    .raster_start(raster_start), .raster_x(raster_x),
    .raster_y(raster_y), .raster_buf(raster_buf),
    .raster_done(raster_done),
    .stream_start(stream_start), .stream_x(stream_x),
    .stream_y(stream_y), .stream_buf(stream_buf),
    .stream_done(stream_done),
    .front_buffer(front_buffer), .frame_done(frame_done),
    .busy(busy)
  );

  tile_scheduler #(
    .SCREEN_W(36), .SCREEN_H(16), .TILE_DIM(8),
    .NUM_BUFS(4), .CW(10)
  ) dutW (
    .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N),
    .frame_start(frame_startW),
    .raster_start(raster_startW), .raster_x(raster_xW),
    .raster_y(raster_yW), .raster_buf(raster_bufW),
    .raster_done(raster_doneW),
    .stream_start(stream_startW), .stream_x(stream_xW),
    .stream_y(stream_yW), .stream_buf(stream_bufW),
    .stream_done(stream_doneW),
    .front_buffer(front_bufferW), .frame_done(frame_doneW),
    .busy(busyW)
  );

  function automatic logic [31:0] pk(input logic [9:0] x,
                                     input logic [9:0] y,
                                     input logic [1:0] b);
    return {10'd0, x, y, b};
  endfunction

  // One clock: sample just after the edge, log starts, and act as
  // rasterizer/streamer answering done 3 cycles after each start.
  task automatic step();
    @(posedge BOARD_CLK);
    #1;
    raster_done  = 1'b0;
    stream_done  = 1'b0;
    raster_doneW = 1'b0;
    stream_doneW = 1'b0;
    if (rPend > 0) begin
      rPend--;
      if (rPend == 0) begin raster_done = 1'b1; rPend = -1; end
    end
    if (sPend > 0 && !stallS) begin
      sPend--;
      if (sPend == 0) begin
        stream_done = 1'b1; sPend = -1; sDones++;
      end
    end
    if (rPendW > 0) begin
      rPendW--;
      if (rPendW == 0) begin raster_doneW = 1'b1; rPendW = -1; end
    end
    if (sPendW > 0) begin
      sPendW--;
      if (sPendW == 0) begin stream_doneW = 1'b1; sPendW = -1; end
    end
    if (raster_start) begin
      rLog.push_back(pk(raster_x, raster_y, {1'b0, raster_buf}));
      rSnap.push_back(sDones);
      if (autoR) rPend = 2;
    end
    if (stream_start) begin
      sLog.push_back(pk(stream_x, stream_y, {1'b0, stream_buf}));
      if (autoS) sPend = 2;
    end
    if (raster_startW) begin
      rLogW.push_back(pk(raster_xW, raster_yW, raster_bufW));
      rPendW = 2;
    end
    if (stream_startW) begin
      sLogW.push_back(pk(stream_xW, stream_yW, stream_bufW));
      sPendW = 2;
    end
    if (frame_done) fdCnt++;
    if (frame_doneW) fdCntW++;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic clear_logs();
    rLog.delete(); sLog.delete(); rSnap.delete();
    fdCnt = 0; sDones = 0;
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 400 && fdCnt == 0; k++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) step();
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    nChecks++;
    if ({raster_x, raster_y, stream_x, stream_y} !== 40'd0) begin
      nFails++;
      $display("FAIL reset_coords got %h exp 0",
               {raster_x, raster_y, stream_x, stream_y});
    end
    nChecks++;
    if ({raster_start, stream_start, raster_buf, stream_buf,
         front_buffer, frame_done} !== 6'd0) begin
      nFails++;
      $display("FAIL reset_ctrl got %b exp 0",
               {raster_start, stream_start, raster_buf, stream_buf,
                front_buffer, frame_done});
    end
    nChecks++;
    if ({busyW, front_bufferW, raster_xW} !== 12'd0) begin
      nFails++;
      $display("FAIL reset_wide got %h exp 0",
               {busyW, front_bufferW, raster_xW});
    end
    RESET_N = 1'b1;
    step();
  endtask

  task automatic test_frame();
    logic [31:0] e, g;
    clear_logs();
    pulse_frame();
    nChecks++;
    if (busy !== 1'b1) begin
      nFails++; $display("FAIL t1_busy_run got %b exp 1", busy);
    end
    wait_frame();
    nChecks++;
    if (rLog.size() !== 8 || sLog.size() !== 8) begin
      nFails++;
      $display("FAIL t1_count got r=%0d s=%0d exp 8",
               rLog.size(), sLog.size());
    end
    for (int i = 0; i < 8; i++) begin
      e = pk(10'((i % 4) * 8), 10'((i / 4) * 8), 2'(i % 2));
      g = (i < rLog.size()) ? rLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t1_raster[%0d] got %h exp %h", i, g, e);
      end
      g = (i < sLog.size()) ? sLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t1_stream[%0d] got %h exp %h", i, g, e);
      end
    end
    nChecks++;
    if (fdCnt !== 1) begin
      nFails++; $display("FAIL t1_frame_done got %0d exp 1", fdCnt);
    end
    nChecks++;
    if (front_buffer !== 1'b1) begin
      nFails++; $display("FAIL t1_front got %b exp 1", front_buffer);
    end
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++; $display("FAIL t1_busy_end got %b exp 0", busy);
    end
  endtask

  task automatic test_stall();
    logic [31:0] e, g;
    clear_logs();
    stallS = 1'b1;
    pulse_frame();
    repeat (20) step();
    nChecks++;
    if (rLog.size() !== 2) begin
      nFails++; $display("FAIL t2_stalled_raster got %0d exp 2", rLog.size());
    end
    nChecks++;
    if (sLog.size() !== 1) begin
      nFails++; $display("FAIL t2_stalled_stream got %0d exp 1", sLog.size());
    end
    stallS = 1'b0;
    for (int k = 0; k < 50 && rLog.size() < 3; k++) step();
    g = (rSnap.size() > 2) ? 32'(rSnap[2]) : '1;
    nChecks++;
    if (g !== 32'd1) begin
      nFails++; $display("FAIL t2_third_after_done got %0d exp 1", g);
    end
    wait_frame();
    for (int i = 0; i < 8; i++) begin
      e = pk(10'((i % 4) * 8), 10'((i / 4) * 8), 2'(i % 2));
      g = (i < sLog.size()) ? sLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t2_stream[%0d] got %h exp %h", i, g, e);
      end
    end
    nChecks++;
    if (fdCnt !== 1 || front_buffer !== 1'b0) begin
      nFails++;
      $display("FAIL t2_flip got fd=%0d front=%b exp fd=1 front=0",
               fdCnt, front_buffer);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] e, g;
    clear_logs();
    autoR = 1'b0; autoS = 1'b0;
    pulse_frame();
    for (int k = 0; k < 20 && rLog.size() < 1; k++) step();
    raster_done = 1'b1;
    step();
    for (int k = 0; k < 20 && (rLog.size() < 2 || sLog.size() < 1); k++)
      step();
    g = (rLog.size() > 1) ? rLog[1] : '1;
    nChecks++;
    if (g !== pk(10'd8, 10'd0, 2'd1)) begin
      nFails++; $display("FAIL t3_raster1 got %h exp %h", g,
                         pk(10'd8, 10'd0, 2'd1));
    end
    raster_done = 1'b1;
    stream_done = 1'b1;
    autoR = 1'b1; autoS = 1'b1;
    step();
    nChecks++;
    if ({dut.fc, dut.rPtr, dut.sPtr} !== 4'b01_0_1) begin
      nFails++;
      $display("FAIL t3_fc_ptrs got %b exp 0101",
               {dut.fc, dut.rPtr, dut.sPtr});
    end
    wait_frame();
    for (int i = 0; i < 8; i++) begin
      e = pk(10'((i % 4) * 8), 10'((i / 4) * 8), 2'(i % 2));
      g = (i < rLog.size()) ? rLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t3_raster[%0d] got %h exp %h", i, g, e);
      end
      g = (i < sLog.size()) ? sLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t3_stream[%0d] got %h exp %h", i, g, e);
      end
    end
    nChecks++;
    if (fdCnt !== 1 || front_buffer !== 1'b1) begin
      nFails++;
      $display("FAIL t3_flip got fd=%0d front=%b exp fd=1 front=1",
               fdCnt, front_buffer);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g;
    clear_logs();
    pulse_frame();
    for (int k = 0; k < 60 && rLog.size() < 4; k++) step();
    #2;
    RESET_N = 1'b0;
    #1;
    nChecks++;
    if (busy !== 1'b0 || front_buffer !== 1'b0) begin
      nFails++;
      $display("FAIL t5_async_state got busy=%b front=%b exp 0 0",
               busy, front_buffer);
    end
    nChecks++;
    if ({raster_x, raster_y, stream_x, stream_y,
         raster_start, stream_start, raster_buf, stream_buf,
         frame_done} !== 45'd0) begin
      nFails++;
      $display("FAIL t5_async_outs got rx=%0d ry=%0d sx=%0d sy=%0d exp 0",
               raster_x, raster_y, stream_x, stream_y);
    end
    rPend = -1; sPend = -1;
    repeat (2) step();
    RESET_N = 1'b1;
    clear_logs();
    step();
    pulse_frame();
    wait_frame();
    g = (rLog.size() > 0) ? rLog[0] : '1;
    nChecks++;
    if (g !== pk(10'd0, 10'd0, 2'd0)) begin
      nFails++; $display("FAIL t5_restart got %h exp 0", g);
    end
    nChecks++;
    if (rLog.size() !== 8 || fdCnt !== 1 || front_buffer !== 1'b1) begin
      nFails++;
      $display("FAIL t5_frame got n=%0d fd=%0d front=%b exp 8 1 1",
               rLog.size(), fdCnt, front_buffer);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] e, g;
    clear_logs();
    stallS = 1'b1;
    pulse_frame();
    repeat (15) step();
    nChecks++;
    if (rLog.size() !== 2 || raster_x !== 10'd16) begin
      nFails++;
      $display("FAIL t4_pre got n=%0d x=%0d exp 2 16",
               rLog.size(), raster_x);
    end
    raster_done = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (3) step();
    nChecks++;
    if ({raster_x, raster_y} !== {10'd16, 10'd0}) begin
      nFails++;
      $display("FAIL t4_spurious got x=%0d y=%0d exp 16 0",
               raster_x, raster_y);
    end
    nChecks++;
    if (rLog.size() !== 2 || busy !== 1'b1) begin
      nFails++;
      $display("FAIL t4_held got n=%0d busy=%b exp 2 1",
               rLog.size(), busy);
    end
    stallS = 1'b0;
    wait_frame();
    for (int i = 0; i < 8; i++) begin
      e = pk(10'((i % 4) * 8), 10'((i / 4) * 8), 2'(i % 2));
      g = (i < rLog.size()) ? rLog[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t4_raster[%0d] got %h exp %h", i, g, e);
      end
    end
    nChecks++;
    if (fdCnt !== 1 || front_buffer !== 1'b0) begin
      nFails++;
      $display("FAIL t4_flip got fd=%0d front=%b exp fd=1 front=0",
               fdCnt, front_buffer);
    end
  endtask

  task automatic test_wide();
    logic [31:0] e, g;
    rLogW.delete(); sLogW.delete(); fdCntW = 0;
    frame_startW = 1'b1;
    step();
    frame_startW = 1'b0;
    for (int k = 0; k < 600 && fdCntW == 0; k++) step();
    repeat (3) step();
    nChecks++;
    if (rLogW.size() !== 10 || sLogW.size() !== 10) begin
      nFails++;
      $display("FAIL t6_count got r=%0d s=%0d exp 10",
               rLogW.size(), sLogW.size());
    end
    for (int i = 0; i < 10; i++) begin
      e = pk(10'((i % 5) * 8), 10'((i / 5) * 8), 2'(i % 4));
      g = (i < rLogW.size()) ? rLogW[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t6_raster[%0d] got %h exp %h", i, g, e);
      end
      g = (i < sLogW.size()) ? sLogW[i] : '1;
      nChecks++;
      if (g !== e) begin
        nFails++; $display("FAIL t6_stream[%0d] got %h exp %h", i, g, e);
      end
    end
    g = (sLogW.size() > 9) ? sLogW[9] : '1;
    nChecks++;
    if (g !== pk(10'd32, 10'd8, 2'd1)) begin
      nFails++; $display("FAIL t6_last got %h exp %h", g,
                         pk(10'd32, 10'd8, 2'd1));
    end
    nChecks++;
    if (fdCntW !== 1 || front_bufferW !== 1'b1 || busyW !== 1'b0) begin
      nFails++;
      $display("FAIL t6_flip got fd=%0d front=%b busy=%b exp 1 1 0",
               fdCntW, front_bufferW, busyW);
    end
  endtask

  initial begin
    frame_start  = 1'b0; raster_done  = 1'b0; stream_done  = 1'b0;
    frame_startW = 1'b0; raster_doneW = 1'b0; stream_doneW = 1'b0;
    test_reset();
    test_frame();
    test_stall();
    test_same_cycle();
    test_reset_mid();
    test_ignore();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
